morse_entry_checker: RTL
========================

Name: morse_entry_checker

Overview:
- Parametrised successor to the player-2 entry block.
- Accumulates decoded Morse symbols (dot = 2'b10, line = 4'b1110, shifted in at the LSB end) into a WIDTH-bit code word, with undo, overflow detection and a registered compare against player 1's target.
- Adds a limited-attempt lockout.
- Sits between the Morse symbol decoder (ld_dot/ld_line pulses) and the game-control/display logic.

Parameters:
- WIDTH, 20, code-word width in bits.
- MAX_SYMBOLS, 10, maximum symbols per entry; also the depth of the symbol-type stack.
- MAX_TRIES, 3, wrong submissions allowed before lockout; must be ≥1.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- ld_dot  in  1  one-cycle pulse: append dot.
- ld_line  in  1  one-cycle pulse: append line.
- ld_undo  in  1  one-cycle pulse: remove last symbol.
- clear_input  in  1  one-cycle pulse: discard entry / leave RESULT.
- done_input  in  1  one-cycle pulse: submit entry.
- target_value  in  WIDTH  player 1 code word; sampled on the done_input cycle.
- q  out  WIDTH  current code word.
- bit_len  out  $clog2(WIDTH+1)  valid bits in q.
- sym_count  out  $clog2(MAX_SYMBOLS+1)  symbols held.
- overflow  out  1  sticky: a symbol was rejected for lack of space.
- result_valid  out  1  compare result available.
- correct  out  1  last submission matched; meaningful only when result_valid=1.
- tries_left  out  $clog2(MAX_TRIES+1)  remaining attempts.
- locked  out  1  attempts exhausted.

Behaviour:
- Reset:
  - q=0, bit_len=0, sym_count=0, overflow=0, result_valid=0, correct=0.
  - tries_left=MAX_TRIES, locked=0, state=ENTRY, type stack cleared.
  - Reset wins over every other input in the same cycle, including mid-entry and in LOCKED.
- States: ENTRY, RESULT, LOCKED.
- ENTRY, per-cycle priority (exactly one action per cycle):
  - Order: done_input > clear_input > ld_undo > ld_line > ld_dot. Lower-priority pulses in that cycle are dropped.
  - dot:
    - If bit_len+2 ≤ WIDTH and sym_count < MAX_SYMBOLS: q ← {q[WIDTH-3:0],2'b10}, bit_len+=2, push type 0.
    - Otherwise set overflow=1 and leave q unchanged.
  - line:
    - If bit_len+4 ≤ WIDTH and sym_count < MAX_SYMBOLS: q ← {q[WIDTH-5:0],4'b1110}, bit_len+=4, push type 1.
    - Otherwise set overflow=1 and leave q unchanged.
  - undo:
    - If sym_count>0: pop the top type; q shifts right logically by 2 (type 0) or 4 (type 1); bit_len and sym_count decrement accordingly.
    - If sym_count=0: no-op.
    - overflow is not cleared by undo.
  - clear: q, bit_len, sym_count, overflow and the stack return to 0; tries_left unchanged.
  - done:
    - Compare target_value against the pre-edge q: match = (q==target_value) && sym_count≠0 && !overflow.
    - Next cycle: state=RESULT, result_valid=1, correct=match. Latency is 1 cycle from the done edge.
    - If !match: tries_left decrements in the same edge.
    - If !match and tries_left was 1: go to LOCKED instead of RESULT, with result_valid=1, correct=0, locked=1.
- RESULT:
  - q and the outputs hold.
  - ld_dot, ld_line, ld_undo and done_input are ignored.
  - clear_input → ENTRY: entry cleared, result_valid=0, correct=0.
  - If the previous result was correct, tries_left reloads to MAX_TRIES; otherwise tries_left is kept.
- LOCKED:
  - All inputs except reset are ignored.
  - Outputs hold, locked=1, tries_left=0.
- Width rules:
  - A maximal entry fills exactly WIDTH bits.
  - MSBs shifted past WIDTH cannot occur, because the overflow guard precedes every shift.
- Outputs are registered, with no combinational path from inputs to outputs.

Test Plan:
- Dot then line, then done with target=0x0002E → q=0x0002E and bit_len=6 before done; one cycle after done: result_valid=1, correct=1, tries_left=3.
- Five lines → q=0xEEEEE, bit_len=20. A sixth line → overflow=1, q unchanged. Dot with bit_len=20 → also rejected. A later done with target=0xEEEEE → correct=0 because of overflow.
- Dot, line, undo → q=0x00002, bit_len=2, sym_count=1. Two more undos → q=0, sym_count=0, second undo is a no-op. Done → correct=0 (empty entry).
- ld_dot and ld_line pulsed in the same cycle → q=0x0000E only. done_input together with ld_dot while q=0x2 → compare uses 0x2 and the dot is dropped.
- Three wrong submissions, each followed by clear → tries_left goes 2, 1, then locked=1 with tries_left=0. Subsequent clear, dot and done have no effect. Reset → ENTRY, tries_left=3, locked=0.
- Reset asserted together with ld_line mid-entry (q=0x2E) → next cycle q=0, bit_len=0, sym_count=0, overflow=0.

Source files
------------

// File: rtl/morse_entry_checker.sv
// morse_entry_checker: player-2 Morse code-word entry with undo, overflow
// detection, registered compare against player 1's target and a limited
// number of attempts before lockout.
module morse_entry_checker #(
  parameter int unsigned WIDTH       = 20,
  parameter int unsigned MAX_SYMBOLS = 10,
  parameter int unsigned MAX_TRIES   = 3
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               ld_dot,
  input  logic                               ld_line,
  input  logic                               ld_undo,
  input  logic                               clear_input,
  input  logic                               done_input,
  input  logic [WIDTH-1:0]                   target_value,
  output logic [WIDTH-1:0]                   q,
  output logic [$clog2(WIDTH+1)-1:0]         bit_len,
  output logic [$clog2(MAX_SYMBOLS+1)-1:0]   sym_count,
  output logic                               overflow,
  output logic                               result_valid,
  output logic                               correct,
  output logic [$clog2(MAX_TRIES+1)-1:0]     tries_left,
  output logic                               locked
);

  localparam int unsigned BLW = $clog2(WIDTH + 1);
  localparam int unsigned SCW = $clog2(MAX_SYMBOLS + 1);
  localparam int unsigned TW  = $clog2(MAX_TRIES + 1);

  typedef enum logic [1:0] {
    ST_ENTRY  = 2'd0,
    ST_RESULT = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t                 state;
  // Symbol-type stack, top of stack at bit 0 (1 = line, 0 = dot).
  logic [MAX_SYMBOLS-1:0] type_stk;

  logic dot_fits;
  logic line_fits;
  logic match;

  // Space checks and submit compare, all evaluated on pre-edge register values.
  always_comb begin
    dot_fits  = ((32'(bit_len) + 32'd2) <= WIDTH) && (32'(sym_count) < MAX_SYMBOLS);
    line_fits = ((32'(bit_len) + 32'd4) <= WIDTH) && (32'(sym_count) < MAX_SYMBOLS);
    match     = (q == target_value) && (sym_count != SCW'(0)) && !overflow;
  end

  // Entry/result/lockout state machine with registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_ENTRY;
      type_stk     <= '0;
      q            <= '0;
      bit_len      <= '0;
      sym_count    <= '0;
      overflow     <= 1'b0;
      result_valid <= 1'b0;
      correct      <= 1'b0;
      tries_left   <= TW'(MAX_TRIES);
      locked       <= 1'b0;
    end else begin
      case (state)
        ST_ENTRY: begin
          if (done_input) begin
            result_valid <= 1'b1;
            correct      <= match;
            if (match) begin
              state <= ST_RESULT;
            end else begin
              tries_left <= tries_left - TW'(1);
              if (tries_left == TW'(1)) begin
                state  <= ST_LOCKED;
                locked <= 1'b1;
              end else begin
                state <= ST_RESULT;
              end
            end
          end else if (clear_input) begin
            q         <= '0;
            bit_len   <= '0;
            sym_count <= '0;
            overflow  <= 1'b0;
            type_stk  <= '0;
          end else if (ld_undo) begin
            if (sym_count != SCW'(0)) begin
              if (type_stk[0]) begin
                q       <= q >> 4;
                bit_len <= bit_len - BLW'(4);
              end else begin
                q       <= q >> 2;
                bit_len <= bit_len - BLW'(2);
              end
              sym_count <= sym_count - SCW'(1);
              type_stk  <= type_stk >> 1;
            end
          end else if (ld_line) begin
            if (line_fits) begin
              q         <= {q[WIDTH-5:0], 4'b1110};
              bit_len   <= bit_len + BLW'(4);
              sym_count <= sym_count + SCW'(1);
              type_stk  <= (type_stk << 1) | MAX_SYMBOLS'(1);
            end else begin
              overflow <= 1'b1;
            end
          end else if (ld_dot) begin
            if (dot_fits) begin
              q         <= {q[WIDTH-3:0], 2'b10};
              bit_len   <= bit_len + BLW'(2);
              sym_count <= sym_count + SCW'(1);
              type_stk  <= type_stk << 1;
            end else begin
              overflow <= 1'b1;
            end
          end
        end

        ST_RESULT: begin
          // Only clear leaves RESULT; a correct result earns a fresh set of tries.
          if (clear_input) begin
            state        <= ST_ENTRY;
            q            <= '0;
            bit_len      <= '0;
            sym_count    <= '0;
            overflow     <= 1'b0;
            type_stk     <= '0;
            result_valid <= 1'b0;
            correct      <= 1'b0;
            if (correct) begin
              tries_left <= TW'(MAX_TRIES);
            end
          end
        end

        ST_LOCKED: begin
          locked     <= 1'b1;
          tries_left <= '0;
        end

        default: begin
          state <= ST_ENTRY;
        end
      endcase
    end
  end

endmodule
